// File: rtl/sparce_sasa_table_if.sv
// Pipeline-side bundle for the SASA table: config store bus, fetch lookup request
// and the registered lookup result.
interface sparce_sasa_table_if #(
  parameter int SASA_ENTRIES = 16
);
  localparam int CW = $clog2(SASA_ENTRIES) + 1;

  logic [31:0]   sasa_addr;
  logic [31:0]   sasa_data;
  logic          sasa_wen;
  logic [31:0]   pc;
  logic          if_ex_enable;
  logic          sasa_hit;
  logic [4:0]    sasa_rs1;
  logic [4:0]    sasa_rs2;
  logic          sasa_cond;
  logic [15:0]   sasa_insts;
  logic [CW-1:0] sasa_count;

  modport master (
    output sasa_addr, sasa_data, sasa_wen, pc, if_ex_enable,
    input  sasa_hit, sasa_rs1, sasa_rs2, sasa_cond, sasa_insts, sasa_count
  );

  modport slave (
    input  sasa_addr, sasa_data, sasa_wen, pc, if_ex_enable,
    output sasa_hit, sasa_rs1, sasa_rs2, sasa_cond, sasa_insts, sasa_count
  );
endinterface

// File: rtl/sparce_sasa_table.sv
// SparCE Skip-Address Skip-Amount table: captures tag/meta config stores and does a
// registered pc lookup. Optional macro SASA_DUP_CHECK_EN updates duplicate tags in place.
module sparce_sasa_table #(
  parameter int          SASA_ENTRIES = 16,
  parameter logic [31:0] SASA_ADDR    = 32'h0000_1000
) (
  input  logic                 CLK,
  input  logic                 nRST,
  sparce_sasa_table_if.slave   bus
);
  localparam int IW = $clog2(SASA_ENTRIES);
  localparam int CW = IW + 1;

  typedef enum logic {IDLE, WAIT_META} state_t;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        cond;
    logic [15:0] insts;
  } meta_t;

  state_t                  state_q, state_d;
  logic                    enable_q;
  logic [IW-1:0]           wp_q;
  logic [CW-1:0]           count_q;
  logic [SASA_ENTRIES-1:0] valid_q;
  logic [31:0]             tag_q;
  logic [31:0]             tag_mem  [SASA_ENTRIES];
  meta_t                   meta_mem [SASA_ENTRIES];

  logic    hit_q;
  meta_t   out_q;

  logic    ctrl_wr, data_wr, clr;
  logic    commit, latch_tag;
  meta_t   meta_in;
  logic    dup_hit;
  logic [IW-1:0] dup_idx, wr_idx;
  logic    lk_hit;
  logic [IW-1:0] lk_idx;

  assign ctrl_wr = bus.sasa_wen && (bus.sasa_addr == SASA_ADDR);
  assign data_wr = bus.sasa_wen && (bus.sasa_addr == SASA_ADDR + 32'd4);
  assign clr     = ctrl_wr && bus.sasa_data[1];

  assign meta_in = '{rs1:   bus.sasa_data[4:0],
                     rs2:   bus.sasa_data[9:5],
                     cond:  bus.sasa_data[10],
                     insts: bus.sasa_data[26:11]};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    commit    = 1'b0;
    latch_tag = 1'b0;
    if (clr) begin
      state_d = IDLE;
    end else if (data_wr) begin
      case (state_q)
        IDLE: begin
          latch_tag = 1'b1;
          state_d   = WAIT_META;
        end
        WAIT_META: begin
          commit  = (meta_in.insts != 16'd0);
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    dup_hit = 1'b0;
    dup_idx = '0;
`ifdef SASA_DUP_CHECK_EN
    for (int i = SASA_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && tag_mem[i] == tag_q) begin
        dup_hit = 1'b1;
        dup_idx = IW'(i);
      end
    end
`endif
  end

  assign wr_idx = dup_hit ? dup_idx : wp_q;

  // Scanning downward lets the lowest matching index be the last (winning) assignment.
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    for (int i = SASA_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && tag_mem[i] == bus.pc) begin
        lk_hit = 1'b1;
        lk_idx = IW'(i);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      enable_q <= 1'b0;
      wp_q     <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      tag_q    <= '0;
    end else begin
      state_q <= state_d;
      if (ctrl_wr) enable_q <= bus.sasa_data[0];
      if (latch_tag) tag_q <= bus.sasa_data;
      if (clr) begin
        valid_q <= '0;
        wp_q    <= '0;
        count_q <= '0;
      end else if (commit) begin
        valid_q[wr_idx] <= 1'b1;
        if (!dup_hit) begin
          wp_q <= wp_q + 1'b1;
          if (count_q != CW'(SASA_ENTRIES)) count_q <= count_q + 1'b1;
        end
      end
    end
  end

  // NOTE: tag/meta storage has no reset; the valid bits alone decide what is visible.
  always_ff @(posedge CLK) begin
    if (commit && !clr) begin
      tag_mem[wr_idx]  <= tag_q;
      meta_mem[wr_idx] <= meta_in;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_q <= 1'b0;
      out_q <= '0;
    end else if (bus.if_ex_enable) begin
      if (clr || !enable_q || !lk_hit) begin
        hit_q <= 1'b0;
        out_q <= '0;
      end else begin
        hit_q <= 1'b1;
        out_q <= meta_mem[lk_idx];
      end
    end
  end

  assign bus.sasa_hit   = hit_q;
  assign bus.sasa_rs1   = out_q.rs1;
  assign bus.sasa_rs2   = out_q.rs2;
  assign bus.sasa_cond  = out_q.cond;
  assign bus.sasa_insts = out_q.insts;
  assign bus.sasa_count = count_q;
endmodule
